// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//
// Collects writeback results from the execute path and the load path and
// drains them, strictly in order, into the register file write port at a
// rate of one write per cycle. It also publishes a per-register pending
// mask so that issue logic can stall on RAW hazards.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous reset, active-high
//   ex_valid   execute result valid
//   ex_rd      execute destination register
//   ex_data    execute result
//   ex_ready   execute result accepted when ex_valid & ex_ready
//   ld_valid   load result valid
//   ld_rd      load destination register
//   ld_data    load result
//   ld_ready   load result accepted when ld_valid & ld_ready
//   rf_we      register file write enable (queue non-empty)
//   rf_waddr   register file write address (head entry, else 0)
//   rf_wdata   register file write data (head entry, else 0)
//   busy_mask  bit i set iff a write to register i is queued; bit 0 always 0
//   count      number of occupied entries
module regfile_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [4:0]                 ex_rd,
    input  logic [XLEN-1:0]            ex_data,
    output logic                       ex_ready,
    input  logic                       ld_valid,
    input  logic [4:0]                 ld_rd,
    input  logic [XLEN-1:0]            ld_data,
    output logic                       ld_ready,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic [31:0]                busy_mask,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            push_ld, push_ex, pop;
    logic [PW-1:0]   ex_slot;

    // Readiness looks only at the registered occupancy; a pop happening in
    // the same cycle is deliberately not credited.
    assign ld_ready = (count_q < CW'(DEPTH));
    assign ex_ready = (count_q < CW'(DEPTH - 1));

    // rd==0 handshakes complete normally but never occupy an entry.
    assign push_ld = ld_valid & ld_ready & (ld_rd != 5'd0);
    assign push_ex = ex_valid & ex_ready & (ex_rd != 5'd0);
    assign pop     = (count_q != '0);

    // The load result is older, so it takes the first free slot and the
    // execute result lands behind it when both arrive together.
    assign ex_slot = push_ld ? (wr_ptr_q + PW'(1)) : wr_ptr_q;

    always_comb begin
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q + PW'(push_ld) + PW'(push_ex);
        count_d  = count_q + CW'(push_ld) + CW'(push_ex) - CW'(pop);
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (push_ld) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
        if (push_ex) begin
            vld_d[ex_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by vld_q/count_q.
    always_ff @(posedge clk) begin
        if (push_ld) begin
            rd_q[wr_ptr_q]   <= ld_rd;
            data_q[wr_ptr_q] <= ld_data;
        end
        if (push_ex) begin
            rd_q[ex_slot]   <= ex_rd;
            data_q[ex_slot] <= ex_data;
        end
    end

    assign rf_we    = pop;
    assign rf_waddr = pop ? rd_q[rd_ptr_q]   : '0;
    assign rf_wdata = pop ? data_q[rd_ptr_q] : '0;
    assign count    = count_q;

    // Pending mask: OR-reduce one-hot destinations of occupied slots, so
    // repeated writes to one register keep its bit set until the last pops.
    logic [DEPTH:0][31:0] mask_acc;
    assign mask_acc[0] = '0;
    for (genvar g = 0; g < DEPTH; g++) begin : g_mask
        assign mask_acc[g+1] = mask_acc[g] | (vld_q[g] ? (32'd1 << rd_q[g]) : 32'd0);
    end
    assign busy_mask = mask_acc[DEPTH] & ~32'd1;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Testbench for regfile_writeback_queue: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, ld_valid;
    logic [4:0]      ex_rd, ld_rd;
    logic [XLEN-1:0] ex_data, ld_data;
    logic            ex_ready, ld_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     busy_mask;
    logic [$clog2(DEPTH+1)-1:0] count;

    always #5 clk = ~clk;

    regfile_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .count(count)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    logic [XLEN-1:0] xreg [32];
    int              checks   = 0;
    int              failures = 0;
    int              pushes   = 0;
    int              writes   = 0;
    bit              last_la, last_ea;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected outputs follow directly from the model queue contents.
    task automatic compare_model();
        logic [31:0] bm;
        int          sz;
        bm = '0;
        sz = mq.size();
        foreach (mq[i]) bm[mq[i].rd] = 1'b1;
        bm[0] = 1'b0;
        chk("ld_ready",  64'(ld_ready),  64'(sz < DEPTH));
        chk("ex_ready",  64'(ex_ready),  64'(sz + 2 <= DEPTH));
        chk("rf_we",     64'(rf_we),     64'(sz != 0));
        chk("rf_waddr",  64'(rf_waddr),  sz != 0 ? 64'(mq[0].rd)   : 64'd0);
        chk("rf_wdata",  64'(rf_wdata),  sz != 0 ? 64'(mq[0].data) : 64'd0);
        chk("busy_mask", 64'(busy_mask), 64'(bm));
        chk("count",     64'(count),     64'(sz));
    endtask

    // One clock: model decides acceptance from its own occupancy, then
    // retires the head and appends accepted results (load before execute).
    task automatic tick();
        bit              la, ea, r;
        logic [4:0]      lrd, erd;
        logic [XLEN-1:0] ldat, edat;
        la   = ld_valid && (mq.size() < DEPTH);
        ea   = ex_valid && (mq.size() + 2 <= DEPTH);
        r    = rst;
        lrd  = ld_rd;  ldat = ld_data;
        erd  = ex_rd;  edat = ex_data;
        if (rf_we && !r) writes++;
        @(posedge clk);
        if (r) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) begin
                xreg[mq[0].rd] = mq[0].data;
                void'(mq.pop_front());
            end
            if (la && lrd != 5'd0) begin mq.push_back('{rd: lrd, data: ldat}); pushes++; end
            if (ea && erd != 5'd0) begin mq.push_back('{rd: erd, data: edat}); pushes++; end
        end
        last_la = la && !r;
        last_ea = ea && !r;
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        ld_valid = 1'b0;
        ex_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        ld_rd = '0; ex_rd = '0; ld_data = '0; ex_data = '0;
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy",  64'(busy_mask), 64'd0);
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);

        // Single execute write, latency one cycle
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
        tick();
        idle();
        chk("t2_we",    64'(rf_we), 64'd1);
        chk("t2_waddr", 64'(rf_waddr), 64'd5);
        chk("t2_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        chk("t2_busy",  64'(busy_mask), 64'h20);
        tick();
        chk("t2_we_off",   64'(rf_we), 64'd0);
        chk("t2_busy_off", 64'(busy_mask), 64'd0);

        // Load and execute to the same register in one cycle
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h22;
        tick();
        idle();
        chk("t3_wdata0", 64'(rf_wdata), 64'h11);
        chk("t3_busy0",  64'(busy_mask), 64'h8);
        chk("t3_count",  64'(count), 64'd2);
        tick();
        chk("t3_wdata1", 64'(rf_wdata), 64'h22);
        chk("t3_busy1",  64'(busy_mask), 64'h8);
        tick();
        chk("t3_we_off", 64'(rf_we), 64'd0);
        chk("t3_x3",     64'(xreg[3]), 64'h22);

        // rd==0 is accepted and discarded
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hFFFFFFFF;
        tick();
        chk("t4_accepted", 64'(last_ea), 64'd1);
        idle();
        chk("t4_we",    64'(rf_we), 64'd0);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_busy",  64'(busy_mask), 64'd0);

        // Both sources saturating for 12 cycles; sources hold until accepted
        ld_valid = 1'b1; ld_rd = 5'($urandom_range(31, 1)); ld_data = $urandom;
        ex_valid = 1'b1; ex_rd = 5'($urandom_range(31, 1)); ex_data = $urandom;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t5_count_max", 64'(count <= 3'(DEPTH)), 64'd1);
            if (last_la) begin ld_rd = 5'($urandom_range(31, 1)); ld_data = $urandom; end
            if (last_ea) begin ex_rd = 5'($urandom_range(31, 1)); ex_data = $urandom; end
        end
        idle();
        repeat (DEPTH + 2) tick();
        chk("t5_all_written", 64'(writes), 64'(pushes));

        // Reset with three entries queued
        ld_valid = 1'b1; ld_rd = 5'd7;  ld_data = 32'hA0000001;
        ex_valid = 1'b1; ex_rd = 5'd8;  ex_data = 32'hA0000002;
        tick();
        ld_rd = 5'd9;  ld_data = 32'hA0000003;
        ex_rd = 5'd10; ex_data = 32'hA0000004;
        tick();
        idle();
        chk("t6_count3", 64'(count), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_we",    64'(rf_we), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_busy",  64'(busy_mask), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_dropped_write", 64'(rf_we), 64'd0);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(63, 0) == 0);
            if (!ld_valid || last_la || rst) begin
                ld_valid = $urandom_range(1, 0) == 1;
                ld_rd    = 5'($urandom_range(31, 0));
                ld_data  = $urandom;
            end
            if (!ex_valid || last_ea || rst) begin
                ex_valid = $urandom_range(1, 0) == 1;
                ex_rd    = 5'($urandom_range(31, 0));
                ex_data  = $urandom;
            end
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (DEPTH + 2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
